// File: rtl/accel_poll_sequencer_if.sv
// Transaction-request bus between the accelerometer sequencer and the I2C controller.
// The master side issues requests; the slave side (controller) accepts them and reports results.
interface accel_poll_sequencer_if;
  logic [6:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr;
  logic       i2c_r_w;
  logic [7:0] i2c_write_data;
  logic       i2c_start;
  logic [7:0] i2c_read_data;
  logic       i2c_done;
  logic       i2c_ready;

  modport master (
    output i2c_dev_addr, i2c_reg_addr, i2c_r_w, i2c_write_data, i2c_start,
    input  i2c_read_data, i2c_done, i2c_ready
  );

  modport slave (
    input  i2c_dev_addr, i2c_reg_addr, i2c_r_w, i2c_write_data, i2c_start,
    output i2c_read_data, i2c_done, i2c_ready
  );
endinterface

// File: rtl/accel_poll_sequencer.sv
// ADXL345 sequencer: checks DEVID, writes three config registers, then polls the six
// data registers on a fixed tick and publishes signed X/Y/Z samples.
module accel_poll_sequencer #(
  parameter int unsigned SYS_CLK_SPEED   = 50000000,
  parameter int unsigned POLL_RATE_HZ    = 100,
  parameter logic [6:0]  DEV_ADDR_P      = 7'h1D,
  parameter logic [7:0]  EXPECTED_ID     = 8'hE5,
  parameter logic [7:0]  BW_RATE_VAL     = 8'h0A,
  parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  accel_poll_sequencer_if.master        i2c,
  output logic [15:0]                   accel_x,
  output logic [15:0]                   accel_y,
  output logic [15:0]                   accel_z,
  output logic                          sample_valid,
  output logic                          init_done,
  output logic [7:0]                    dev_id,
  output logic                          fault,
  output logic [1:0]                    fault_code,
  output logic                          overrun
);

  localparam int unsigned POLL_DIV = SYS_CLK_SPEED / POLL_RATE_HZ;
  localparam int TICK_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_TXN_ID, S_CFG_BW, S_CFG_FMT, S_CFG_PWR,
    S_WAIT_TICK, S_READ_DATA, S_PUBLISH, S_FAULT
  } state_e;

  typedef enum logic {PH_ISSUE, PH_WAIT} phase_e;

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [TMO_W-1:0]  timer_q, timer_d;
  logic [2:0]        idx_q, idx_d;
  logic              start_q, start_d;
  logic [7:0]        reg_addr_q, reg_addr_d;
  logic              r_w_q, r_w_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        dev_id_q, dev_id_d;
  logic [1:0]        fault_code_q, fault_code_d;
  logic              init_done_q, init_done_d;
  logic              sample_valid_q, sample_valid_d;
  logic [15:0]       accel_x_q, accel_x_d;
  logic [15:0]       accel_y_q, accel_y_d;
  logic [15:0]       accel_z_q, accel_z_d;

  logic [TICK_W-1:0] tick_q;
  logic              pending_q;
  logic              overrun_q;
  logic              tick;
  logic              consume;

  logic [7:0]        shadow_q [6];
  logic              shadow_we;

  logic              txn_done;
  logic              launch;
  logic [7:0]        launch_reg;
  logic              launch_rw;
  logic [7:0]        launch_data;
  logic              enter_fault;
  logic [1:0]        fault_code_new;

  assign txn_done = (phase_q == PH_WAIT) && i2c.i2c_done && i2c.i2c_ready;
  assign tick     = (tick_q == TICK_W'(POLL_DIV - 1));

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    timer_d        = timer_q;
    idx_d          = idx_q;
    start_d        = start_q;
    reg_addr_d     = reg_addr_q;
    r_w_d          = r_w_q;
    wdata_d        = wdata_q;
    dev_id_d       = dev_id_q;
    fault_code_d   = fault_code_q;
    init_done_d    = init_done_q;
    sample_valid_d = 1'b0;
    accel_x_d      = accel_x_q;
    accel_y_d      = accel_y_q;
    accel_z_d      = accel_z_q;
    consume        = 1'b0;
    shadow_we      = 1'b0;
    launch         = 1'b0;
    launch_reg     = 8'h00;
    launch_rw      = 1'b0;
    launch_data    = 8'h00;
    enter_fault    = 1'b0;
    fault_code_new = 2'b00;

    case (state_q)
      S_TXN_ID, S_CFG_BW, S_CFG_FMT, S_CFG_PWR, S_READ_DATA: begin
        timer_d = timer_q + TMO_W'(1);
        if (phase_q == PH_ISSUE) begin
          // Only the DEVID read after reset enters ISSUE with start low (reg 0x00 already loaded).
          if (!start_q) begin
            start_d = 1'b1;
            r_w_d   = 1'b1;
          end else if (!i2c.i2c_ready) begin
            phase_d = PH_WAIT;
            start_d = 1'b0;
          end
        end
        if (txn_done) begin
          case (state_q)
            S_TXN_ID: begin
              dev_id_d = i2c.i2c_read_data;
              if (i2c.i2c_read_data != EXPECTED_ID) begin
                enter_fault    = 1'b1;
                fault_code_new = 2'b01;
              end else begin
                state_d     = S_CFG_BW;
                launch      = 1'b1;
                launch_reg  = 8'h2C;
                launch_data = BW_RATE_VAL;
              end
            end
            S_CFG_BW: begin
              state_d     = S_CFG_FMT;
              launch      = 1'b1;
              launch_reg  = 8'h31;
              launch_data = DATA_FORMAT_VAL;
            end
            S_CFG_FMT: begin
              state_d     = S_CFG_PWR;
              launch      = 1'b1;
              launch_reg  = 8'h2D;
              launch_data = 8'h08;
            end
            S_CFG_PWR: begin
              state_d     = S_WAIT_TICK;
              init_done_d = 1'b1;
            end
            S_READ_DATA: begin
              shadow_we = 1'b1;
              if (idx_q == 3'd5) begin
                // Last byte bypasses the shadow so all axes land together one cycle after done.
                state_d        = S_PUBLISH;
                sample_valid_d = 1'b1;
                accel_x_d      = {shadow_q[1], shadow_q[0]};
                accel_y_d      = {shadow_q[3], shadow_q[2]};
                accel_z_d      = {i2c.i2c_read_data, shadow_q[4]};
              end else begin
                idx_d      = idx_q + 3'd1;
                launch     = 1'b1;
                launch_reg = 8'h33 + {5'b00000, idx_q};
                launch_rw  = 1'b1;
              end
            end
            default: ;
          endcase
        end else if (timer_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          enter_fault    = 1'b1;
          fault_code_new = 2'b10;
        end
      end
      S_WAIT_TICK: begin
        if (pending_q) begin
          consume    = 1'b1;
          idx_d      = 3'd0;
          state_d    = S_READ_DATA;
          launch     = 1'b1;
          launch_reg = 8'h32;
          launch_rw  = 1'b1;
        end
      end
      S_PUBLISH: state_d = S_WAIT_TICK;
      default: ;
    endcase

    if (launch) begin
      phase_d    = PH_ISSUE;
      timer_d    = '0;
      start_d    = 1'b1;
      reg_addr_d = launch_reg;
      r_w_d      = launch_rw;
      wdata_d    = launch_data;
    end
    if (enter_fault) begin
      state_d      = S_FAULT;
      start_d      = 1'b0;
      fault_code_d = fault_code_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_TXN_ID;
      phase_q        <= PH_ISSUE;
      timer_q        <= '0;
      idx_q          <= '0;
      start_q        <= 1'b0;
      reg_addr_q     <= 8'h00;
      r_w_q          <= 1'b0;
      wdata_q        <= 8'h00;
      dev_id_q       <= 8'h00;
      fault_code_q   <= 2'b00;
      init_done_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      accel_x_q      <= 16'h0000;
      accel_y_q      <= 16'h0000;
      accel_z_q      <= 16'h0000;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      timer_q        <= timer_d;
      idx_q          <= idx_d;
      start_q        <= start_d;
      reg_addr_q     <= reg_addr_d;
      r_w_q          <= r_w_d;
      wdata_q        <= wdata_d;
      dev_id_q       <= dev_id_d;
      fault_code_q   <= fault_code_d;
      init_done_q    <= init_done_d;
      sample_valid_q <= sample_valid_d;
      accel_x_q      <= accel_x_d;
      accel_y_q      <= accel_y_d;
      accel_z_q      <= accel_z_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shadow_we) shadow_q[idx_q] <= i2c.i2c_read_data;
  end

  // A tick coinciding with consumption re-arms pending; ticks before init never count as overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tick_q    <= tick ? '0 : tick_q + TICK_W'(1);
      pending_q <= tick | (pending_q & ~consume);
      if (tick && pending_q && !consume && init_done_q) overrun_q <= 1'b1;
    end
  end

  assign i2c.i2c_dev_addr   = DEV_ADDR_P;
  assign i2c.i2c_reg_addr   = reg_addr_q;
  assign i2c.i2c_r_w        = r_w_q;
  assign i2c.i2c_write_data = wdata_q;
  assign i2c.i2c_start      = start_q;

  assign accel_x      = accel_x_q;
  assign accel_y      = accel_y_q;
  assign accel_z      = accel_z_q;
  assign sample_valid = sample_valid_q;
  assign init_done    = init_done_q;
  assign dev_id       = dev_id_q;
  assign fault        = (state_q == S_FAULT);
  assign fault_code   = fault_code_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_accel_poll_sequencer.sv
// Directed bench for accel_poll_sequencer with a behavioural I2C controller model
// (configurable latency, DEVID value, data bytes, and a never-finish mode).
module tb_accel_poll_sequencer;
  localparam int POLL_DIV = 2000;
  localparam int TMO      = 5000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] accel_x, accel_y, accel_z;
  logic        sample_valid, init_done, fault, overrun;
  logic [7:0]  dev_id;
  logic [1:0]  fault_code;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  accel_poll_sequencer_if bus ();

  accel_poll_sequencer #(
    .SYS_CLK_SPEED (200000),
    .POLL_RATE_HZ  (100),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i2c         (bus.master),
    .accel_x     (accel_x),
    .accel_y     (accel_y),
    .accel_z     (accel_z),
    .sample_valid(sample_valid),
    .init_done   (init_done),
    .dev_id      (dev_id),
    .fault       (fault),
    .fault_code  (fault_code),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Controller model: acts on the falling edge, logs every accepted request.
  int         lat = 200;
  bit         hang = 1'b0;
  logic [7:0] id_val = 8'hE5;
  logic [7:0] data_b [6];
  logic [7:0] log_reg [64];
  logic       log_rw [64];
  logic [7:0] log_wd [64];
  int         log_cnt = 0;
  bit         busy = 1'b0;
  int         mcnt = 0;
  logic [7:0] cur_reg = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      bus.i2c_ready     = 1'b1;
      bus.i2c_done      = 1'b0;
      bus.i2c_read_data = 8'h00;
      busy    = 1'b0;
      mcnt    = 0;
      log_cnt = 0;
    end else if (!busy && bus.i2c_start && bus.i2c_ready) begin
      if (log_cnt < 64) begin
        log_reg[log_cnt] = bus.i2c_reg_addr;
        log_rw[log_cnt]  = bus.i2c_r_w;
        log_wd[log_cnt]  = bus.i2c_write_data;
      end
      $display("txn %0d: reg %02h %s wdata %02h", log_cnt, bus.i2c_reg_addr,
               bus.i2c_r_w ? "rd" : "wr", bus.i2c_write_data);
      log_cnt = log_cnt + 1;
      cur_reg = bus.i2c_reg_addr;
      busy = 1'b1;
      mcnt = 0;
      bus.i2c_ready = 1'b0;
      bus.i2c_done  = 1'b0;
    end else if (busy) begin
      mcnt = mcnt + 1;
      if (!hang && mcnt >= lat) begin
        busy = 1'b0;
        bus.i2c_ready = 1'b1;
        bus.i2c_done  = 1'b1;
        if (cur_reg == 8'h00) bus.i2c_read_data = id_val;
        else if (cur_reg >= 8'h32 && cur_reg <= 8'h37) bus.i2c_read_data = data_b[cur_reg - 8'h32];
        else bus.i2c_read_data = 8'h00;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    vectors++; if (bus.i2c_start !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b expected 0", bus.i2c_start); end
    vectors++; if (bus.i2c_dev_addr !== 7'h1D) begin miscompares++; $display("FAIL reset_dev_addr: got %h expected 1d", bus.i2c_dev_addr); end
    vectors++; if ({bus.i2c_reg_addr, bus.i2c_r_w, bus.i2c_write_data} !== 17'h0) begin miscompares++; $display("FAIL reset_req: got %h expected 0", {bus.i2c_reg_addr, bus.i2c_r_w, bus.i2c_write_data}); end
    vectors++; if ({accel_x, accel_y, accel_z} !== 48'h0) begin miscompares++; $display("FAIL reset_accel: got %h expected 0", {accel_x, accel_y, accel_z}); end
    vectors++; if ({sample_valid, init_done, dev_id, fault, fault_code, overrun} !== 14'h0) begin miscompares++; $display("FAIL reset_status: got %h expected 0", {sample_valid, init_done, dev_id, fault, fault_code, overrun}); end
  endtask

  task automatic test_init_sequence();
    logic [7:0] exp_reg [4] = '{8'h00, 8'h2C, 8'h31, 8'h2D};
    logic       exp_rw  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] exp_wd  [4] = '{8'h00, 8'h0A, 8'h0B, 8'h08};
    int n = 0;
    lat = 200; hang = 1'b0; id_val = 8'hE5;
    data_b[0] = 8'h34; data_b[1] = 8'h12; data_b[2] = 8'hFF;
    data_b[3] = 8'hFF; data_b[4] = 8'h00; data_b[5] = 8'h80;
    rst = 1'b0;
    while (init_done !== 1'b1 && n < 3000) begin step(); n++; end
    vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL init_done: got %b expected 1", init_done); end
    vectors++; if (log_cnt !== 4) begin miscompares++; $display("FAIL init_txn_count: got %0d expected 4", log_cnt); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (log_reg[i] !== exp_reg[i] || log_rw[i] !== exp_rw[i] || (!exp_rw[i] && log_wd[i] !== exp_wd[i])) begin
        miscompares++;
        $display("FAIL init_txn%0d: got reg %h rw %b wd %h expected reg %h rw %b wd %h",
                 i, log_reg[i], log_rw[i], log_wd[i], exp_reg[i], exp_rw[i], exp_wd[i]);
      end
    end
    vectors++; if (dev_id !== 8'hE5) begin miscompares++; $display("FAIL init_dev_id: got %h expected e5", dev_id); end
    vectors++; if (accel_x !== 16'h0000) begin miscompares++; $display("FAIL init_accel_hold: got %h expected 0000", accel_x); end
  endtask

  task automatic test_sample();
    int n = 0;
    do begin step(); n++; end while (sample_valid !== 1'b1 && n < 3000);
    vectors++; if (sample_valid !== 1'b1) begin miscompares++; $display("FAIL sample_pulse: got %b expected 1", sample_valid); end
    vectors++; if (accel_x !== 16'h1234) begin miscompares++; $display("FAIL sample_x: got %h expected 1234", accel_x); end
    vectors++; if (accel_y !== 16'hFFFF) begin miscompares++; $display("FAIL sample_y: got %h expected ffff", accel_y); end
    vectors++; if (accel_z !== 16'h8000) begin miscompares++; $display("FAIL sample_z: got %h expected 8000", accel_z); end
    vectors++; if (log_cnt !== 10) begin miscompares++; $display("FAIL sample_txn_count: got %0d expected 10", log_cnt); end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (log_reg[4+i] !== 8'h32 + 8'(i) || log_rw[4+i] !== 1'b1) begin
        miscompares++;
        $display("FAIL sample_read%0d: got reg %h rw %b expected reg %h rw 1", i, log_reg[4+i], log_rw[4+i], 8'h32 + 8'(i));
      end
    end
    step();
    vectors++; if (sample_valid !== 1'b0) begin miscompares++; $display("FAIL sample_single: got %b expected 0", sample_valid); end
  endtask

  task automatic test_poll_spacing();
    int t [3];
    int n;
    lat = 10;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin step(); n++; end while (sample_valid !== 1'b1 && n < 2500);
      t[k] = cyc;
    end
    vectors++; if (sample_valid !== 1'b1) begin miscompares++; $display("FAIL spacing_wait: got %b expected 1", sample_valid); end
    vectors++; if (t[1] - t[0] !== POLL_DIV) begin miscompares++; $display("FAIL spacing_1: got %0d expected %0d", t[1] - t[0], POLL_DIV); end
    vectors++; if (t[2] - t[1] !== POLL_DIV) begin miscompares++; $display("FAIL spacing_2: got %0d expected %0d", t[2] - t[1], POLL_DIV); end
    vectors++; if ({overrun, fault} !== 2'b00) begin miscompares++; $display("FAIL spacing_flags: got %b expected 00", {overrun, fault}); end
  endtask

  task automatic test_id_mismatch();
    int n = 0;
    int starts = 0;
    rst = 1'b1;
    repeat (3) step();
    lat = 200; id_val = 8'hE4;
    rst = 1'b0;
    while (fault !== 1'b1 && n < 1000) begin step(); n++; end
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL id_fault: got %b expected 1", fault); end
    vectors++; if (fault_code !== 2'b01) begin miscompares++; $display("FAIL id_fault_code: got %b expected 01", fault_code); end
    vectors++; if (dev_id !== 8'hE4) begin miscompares++; $display("FAIL id_dev_id: got %h expected e4", dev_id); end
    for (int i = 0; i < 2500; i++) begin
      step();
      if (bus.i2c_start === 1'b1) starts++;
    end
    vectors++; if (starts !== 0) begin miscompares++; $display("FAIL id_no_start: got %0d expected 0", starts); end
    vectors++; if (log_cnt !== 1 || init_done !== 1'b0) begin miscompares++; $display("FAIL id_no_txn: got %0d/%b expected 1/0", log_cnt, init_done); end
  endtask

  task automatic test_overrun();
    int n = 0;
    int t1;
    rst = 1'b1;
    repeat (3) step();
    lat = 600; id_val = 8'hE5;
    data_b[0] = 8'h01; data_b[1] = 8'h00; data_b[2] = 8'h00;
    data_b[3] = 8'h7F; data_b[4] = 8'hFE; data_b[5] = 8'hFF;
    rst = 1'b0;
    while (init_done !== 1'b1 && n < 4000) begin step(); n++; end
    vectors++; if (init_done !== 1'b1 || log_cnt !== 4) begin miscompares++; $display("FAIL ovr_init: got %b/%0d expected 1/4", init_done, log_cnt); end
    vectors++; if ({bus.i2c_start, overrun} !== 2'b00) begin miscompares++; $display("FAIL ovr_pre_poll: got %b expected 00", {bus.i2c_start, overrun}); end
    step();
    vectors++; if (bus.i2c_start !== 1'b1 || bus.i2c_reg_addr !== 8'h32) begin miscompares++; $display("FAIL ovr_poll_immediate: got %b/%h expected 1/32", bus.i2c_start, bus.i2c_reg_addr); end
    n = 0;
    do begin step(); n++; end while (sample_valid !== 1'b1 && n < 5000);
    t1 = cyc;
    vectors++; if ({accel_x, accel_y, accel_z} !== 48'h0001_7F00_FFFE) begin miscompares++; $display("FAIL ovr_sample: got %h expected 00017f00fffe", {accel_x, accel_y, accel_z}); end
    n = 0;
    do begin step(); n++; end while (sample_valid !== 1'b1 && n < 5000);
    vectors++; if (cyc - t1 !== 6 * 601 + 2) begin miscompares++; $display("FAIL ovr_back_to_back: got %0d expected %0d", cyc - t1, 6 * 601 + 2); end
    vectors++; if ({overrun, fault} !== 2'b10) begin miscompares++; $display("FAIL ovr_flags: got %b expected 10", {overrun, fault}); end
  endtask

  task automatic test_mid_reset();
    repeat (100) step();
    rst = 1'b1;
    repeat (2) step();
    vectors++; if ({accel_x, accel_y, accel_z} !== 48'h0) begin miscompares++; $display("FAIL midrst_accel: got %h expected 0", {accel_x, accel_y, accel_z}); end
    vectors++; if ({sample_valid, init_done, dev_id, fault, fault_code, overrun} !== 14'h0) begin miscompares++; $display("FAIL midrst_status: got %h expected 0", {sample_valid, init_done, dev_id, fault, fault_code, overrun}); end
    vectors++; if ({bus.i2c_start, bus.i2c_reg_addr, bus.i2c_r_w} !== 10'h0 || bus.i2c_dev_addr !== 7'h1D) begin miscompares++; $display("FAIL midrst_bus: got %h/%h expected 0/1d", {bus.i2c_start, bus.i2c_reg_addr, bus.i2c_r_w}, bus.i2c_dev_addr); end
  endtask

  task automatic test_restart();
    int n = 0;
    lat = 20;
    rst = 1'b0;
    while (log_cnt < 1 && n < 50) begin step(); n++; end
    vectors++; if (log_cnt < 1 || log_reg[0] !== 8'h00 || log_rw[0] !== 1'b1) begin miscompares++; $display("FAIL restart_first_txn: got %0d/%h/%b expected 1/00/1", log_cnt, log_reg[0], log_rw[0]); end
    n = 0;
    while (init_done !== 1'b1 && n < 300) begin step(); n++; end
    vectors++; if (init_done !== 1'b1) begin miscompares++; $display("FAIL restart_init: got %b expected 1", init_done); end
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    repeat (3) step();
    hang = 1'b1;
    rst = 1'b0;
    repeat (TMO - 1) step();
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL tmo_early: got %b expected 0", fault); end
    step();
    vectors++; if (fault !== 1'b1 || fault_code !== 2'b10) begin miscompares++; $display("FAIL tmo_fault: got %b/%b expected 1/10", fault, fault_code); end
    vectors++; if (bus.i2c_start !== 1'b0 || log_cnt !== 1) begin miscompares++; $display("FAIL tmo_bus: got %b/%0d expected 0/1", bus.i2c_start, log_cnt); end
    rst = 1'b1;
    step();
    hang = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_sample();
    test_poll_spacing();
    test_id_mismatch();
    test_overrun();
    test_mid_reset();
    test_restart();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
